// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues icache requests and buffers
// returned words with their PCs in an in-order prefetch FIFO for the scheduler.
module fetch_unit #(
  parameter int                WORD_W     = 32,
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    FETCH,
    FULL,
    HALTED
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              req_en;
  logic              push;
  logic              pop;
  logic [WORD_W-1:0] mem_instr [FIFO_DEPTH];
  logic [WORD_W-1:0] mem_pc    [FIFO_DEPTH];

  // req_en is the registered permission to fetch; redirect and halt veto it
  // in the same cycle so a coincident hit is never pushed.
  assign imemREN     = req_en & ~redirect & ~halt;
  assign imemaddr    = pc;
  assign push        = imemREN & ihit;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid & instr_ready;
  assign instr       = mem_instr[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];
  assign count_next  = count + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      req_en <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (redirect) begin
      // Flush everything and restart sequential fetch at the aligned target.
      state  <= FETCH;
      pc     <= {redirect_pc[WORD_W-1:2], 2'b00};
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      req_en <= 1'b1;
    end else begin
      if (push) begin
        mem_instr[wr_ptr] <= imemload;
        mem_pc[wr_ptr]    <= pc;
        wr_ptr            <= wr_ptr + PTR_W'(1);
        pc                <= pc + WORD_W'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_next;

      if (halt || state == HALTED) begin
        state  <= HALTED;
        req_en <= 1'b0;
      end else if (state == FULL) begin
        if (pop) begin
          state  <= FETCH;
          req_en <= 1'b1;
        end
      end else if (count_next == DEPTH_C) begin
        state  <= FULL;
        req_en <= 1'b0;
      end else begin
        state  <= FETCH;
        req_en <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: one vector per clock cycle,
// plus a hand-written asynchronous reset during an icache miss.
module tb_fetch_unit;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic        ihit;
    logic [31:0] load;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        ready;
    logic        expRen;
    logic [31:0] expAddr;
    logic        expValid;
    logic        chkData;
    logic [31:0] expInstr;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs [29];

  fetch_unit dut (
    .CLK(CLK),
    .nRST(nRST),
    .imemREN(imemREN),
    .imemaddr(imemaddr),
    .ihit(ihit),
    .imemload(imemload),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic hit, input logic [31:0] ld,
                              input logic rd, input logic [31:0] rp,
                              input logic hl, input logic rdy,
                              input logic eRen, input logic [31:0] eAddr,
                              input logic eValid, input logic chk,
                              input logic [31:0] eInstr, input logic [31:0] ePc);
    vec_t v;
    v.ihit = hit;   v.load = ld;      v.redir = rd;       v.rpc = rp;
    v.halt = hl;    v.ready = rdy;    v.expRen = eRen;    v.expAddr = eAddr;
    v.expValid = eValid; v.chkData = chk; v.expInstr = eInstr; v.expPc = ePc;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    ihit        = v.ihit;
    imemload    = v.load;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    halt        = v.halt;
    instr_ready = v.ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  initial begin
    // Sequential hits, backpressure to FULL, miss stall, redirect, halt,
    // halt+redirect together, and PC wrap at the top of the address space.
    vecs[0]  = mk(1, 32'hA5A5_0000, 0, 0, 0, 1, 0, 32'h00, 0, 1, 32'h0, 32'h0);
    vecs[1]  = mk(1, 32'hA5A5_0000, 0, 0, 0, 1, 1, 32'h00, 0, 1, 32'h0, 32'h0);
    vecs[2]  = mk(1, 32'hA5A5_0004, 0, 0, 0, 1, 1, 32'h04, 1, 1, 32'hA5A5_0000, 32'h00);
    vecs[3]  = mk(1, 32'hA5A5_0008, 0, 0, 0, 1, 1, 32'h08, 1, 1, 32'hA5A5_0004, 32'h04);
    vecs[4]  = mk(1, 32'hA5A5_000C, 0, 0, 0, 0, 1, 32'h0C, 1, 1, 32'hA5A5_0008, 32'h08);
    vecs[5]  = mk(1, 32'hA5A5_0010, 0, 0, 0, 0, 1, 32'h10, 1, 1, 32'hA5A5_0008, 32'h08);
    vecs[6]  = mk(1, 32'hA5A5_0014, 0, 0, 0, 0, 1, 32'h14, 1, 1, 32'hA5A5_0008, 32'h08);
    vecs[7]  = mk(1, 32'hA5A5_0018, 0, 0, 0, 0, 0, 32'h18, 1, 1, 32'hA5A5_0008, 32'h08);
    vecs[8]  = mk(1, 32'hA5A5_0018, 0, 0, 0, 1, 0, 32'h18, 1, 1, 32'hA5A5_0008, 32'h08);
    vecs[9]  = mk(0, 32'h0,         0, 0, 0, 0, 1, 32'h18, 1, 1, 32'hA5A5_000C, 32'h0C);
    vecs[10] = mk(0, 32'h0,         0, 0, 0, 0, 1, 32'h18, 1, 1, 32'hA5A5_000C, 32'h0C);
    vecs[11] = mk(1, 32'hA5A5_0018, 0, 0, 0, 0, 1, 32'h18, 1, 1, 32'hA5A5_000C, 32'h0C);
    vecs[12] = mk(1, 32'hA5A5_001C, 0, 0, 0, 1, 0, 32'h1C, 1, 1, 32'hA5A5_000C, 32'h0C);
    vecs[13] = mk(1, 32'hA5A5_001C, 1, 32'h103, 0, 1, 0, 32'h1C, 1, 1, 32'hA5A5_0010, 32'h10);
    vecs[14] = mk(0, 32'h0,         0, 0, 0, 1, 1, 32'h100, 0, 0, 32'h0, 32'h0);
    vecs[15] = mk(1, 32'hDEAD_0100, 0, 0, 0, 1, 1, 32'h100, 0, 0, 32'h0, 32'h0);
    vecs[16] = mk(1, 32'hDEAD_0104, 0, 0, 1, 0, 0, 32'h104, 1, 1, 32'hDEAD_0100, 32'h100);
    vecs[17] = mk(1, 32'hDEAD_0104, 0, 0, 0, 0, 0, 32'h104, 1, 1, 32'hDEAD_0100, 32'h100);
    vecs[18] = mk(0, 32'h0,         0, 0, 0, 1, 0, 32'h104, 1, 1, 32'hDEAD_0100, 32'h100);
    vecs[19] = mk(0, 32'h0,         0, 0, 0, 1, 0, 32'h104, 0, 0, 32'h0, 32'h0);
    vecs[20] = mk(1, 32'hDEAD_0104, 1, 32'h40, 1, 1, 0, 32'h104, 0, 0, 32'h0, 32'h0);
    vecs[21] = mk(1, 32'h0000_0040, 0, 0, 0, 0, 1, 32'h40, 0, 0, 32'h0, 32'h0);
    vecs[22] = mk(0, 32'h0,         0, 0, 0, 1, 1, 32'h44, 1, 1, 32'h0000_0040, 32'h40);
    vecs[23] = mk(1, 32'h0000_0044, 1, 32'hFFFF_FFFF, 0, 1, 0, 32'h44, 0, 0, 32'h0, 32'h0);
    vecs[24] = mk(1, 32'h1111_1111, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0);
    vecs[25] = mk(1, 32'h2222_2222, 0, 0, 0, 0, 1, 32'h0, 1, 1, 32'h1111_1111, 32'hFFFF_FFFC);
    vecs[26] = mk(0, 32'h0,         0, 0, 0, 1, 1, 32'h4, 1, 1, 32'h1111_1111, 32'hFFFF_FFFC);
    vecs[27] = mk(0, 32'h0,         0, 0, 0, 1, 1, 32'h4, 1, 1, 32'h2222_2222, 32'h0);
    vecs[28] = mk(0, 32'h0,         0, 0, 0, 1, 1, 32'h4, 0, 0, 32'h0, 32'h0);

    nRST = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    checkOutput("reset imemREN", {31'b0, imemREN}, 32'h0);
    checkOutput("reset imemaddr", imemaddr, 32'h0);
    checkOutput("reset instr_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("reset instr", instr, 32'h0);
    checkOutput("reset instr_pc", instr_pc, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 29; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d imemREN", i), {31'b0, imemREN}, {31'b0, vecs[i].expRen});
      checkOutput($sformatf("v%0d imemaddr", i), imemaddr, vecs[i].expAddr);
      checkOutput($sformatf("v%0d instr_valid", i), {31'b0, instr_valid},
                  {31'b0, vecs[i].expValid});
      if (vecs[i].chkData) begin
        checkOutput($sformatf("v%0d instr", i), instr, vecs[i].expInstr);
        checkOutput($sformatf("v%0d instr_pc", i), instr_pc, vecs[i].expPc);
      end
      @(negedge CLK);
    end

    // Asynchronous reset asserted between edges while a miss is outstanding.
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    @(posedge CLK);
    #3;
    checkOutput("miss imemREN", {31'b0, imemREN}, 32'h1);
    checkOutput("miss imemaddr", imemaddr, 32'h4);
    nRST = 1'b0;
    #1;
    checkOutput("async rst imemREN", {31'b0, imemREN}, 32'h0);
    checkOutput("async rst imemaddr", imemaddr, 32'h0);
    checkOutput("async rst instr_valid", {31'b0, instr_valid}, 32'h0);
    checkOutput("async rst instr", instr, 32'h0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checkOutput("post rst imemREN", {31'b0, imemREN}, 32'h0);
    @(negedge CLK);
    #1;
    checkOutput("restart imemREN", {31'b0, imemREN}, 32'h1);
    checkOutput("restart imemaddr", imemaddr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage, directly upstream of the instruction cache.
- Owns the PC and drives `imemREN`/`imemaddr` into the icache.
- Each `ihit` captures the returned word, with its PC, into a small in-order prefetch FIFO.
- The FIFO feeds the scheduler through a valid/ready handshake; branch redirect and halt come from the scheduler.

Parameters:
- WORD_W, 32, instruction and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, at least 2.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- imemREN  output  1  fetch request to icache.
- imemaddr  output  WORD_W  fetch address; equals PC, word aligned.
- ihit  input  1  icache hit; data valid on imemload this cycle.
- imemload  input  WORD_W  instruction word from icache.
- redirect  input  1  scheduler branch/jump redirect, single-cycle pulse.
- redirect_pc  input  WORD_W  redirect target; bits [1:0] ignored (forced 0).
- halt  input  1  stop fetching; sticky until redirect.
- instr_valid  output  1  FIFO head valid.
- instr  output  WORD_W  FIFO head instruction.
- instr_pc  output  WORD_W  FIFO head PC.
- instr_ready  input  1  scheduler consumes head when high with instr_valid.

Behaviour:
- Reset (async): PC=RESET_PC, FIFO empty, count=0, state=FETCH. Outputs: imemREN=0, imemaddr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- FSM states:
  - FETCH: imemREN=1 iff count<FIFO_DEPTH and no redirect this cycle. Go to FULL when the push fills the FIFO (count reaches DEPTH with no pop). Go to HALTED on halt.
  - FULL: imemREN=0. Return to FETCH when a pop occurs.
  - HALTED: imemREN=0; FIFO still drains. Leave to FETCH only on redirect.
- Request/hit:
  - imemaddr is combinationally PC.
  - While imemREN=1 and ihit=0 (icache miss), hold PC and imemREN stable every cycle.
  - On imemREN & ihit: push {PC, imemload} at tail; next-cycle PC=PC+4.
  - Hit latency is 0 (same cycle) on hit, N cycles on miss; the unit makes no assumption about N.
- PC arithmetic: modulo 2^WORD_W; PC=32'hFFFF_FFFC+4 wraps to 0 with no error.
- FIFO:
  - Head drives instr/instr_pc; instr_valid=(count!=0).
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle is legal when count<DEPTH; count unchanged.
  - When full, push cannot occur (imemREN=0), so push-when-full is impossible by construction.
  - Pointers wrap modulo FIFO_DEPTH.
- Redirect, highest priority:
  - Same cycle: imemREN forced 0. Any ihit that cycle is discarded (no push).
  - Same cycle: any pop is still honoured by the scheduler-side handshake, but the FIFO is then flushed.
  - Next cycle: PC=redirect_pc & ~3, count=0, pointers=0, state=FETCH (overrides halt and FULL).
  - Redirect during an outstanding miss abandons it; the new address is presented the following cycle.
- Halt: takes effect the cycle asserted. Halt & ihit in the same cycle: hit discarded, PC unchanged. Halt & redirect together: redirect wins, state=FETCH.
- Fetches are strictly in order; no speculation beyond sequential PC+4.
- Reset mid-operation: all state returns to reset values immediately; in-flight data dropped.

Test Plan:
- Sequential hits: RESET_PC=0, ihit tied 1, instr_ready=1, imemload=addr^32'hA5A5_0000 → instr_pc 0,4,8,C… one per cycle after first, matching instr values.
- Miss stall: ihit low 5 cycles at PC=0x10 → imemaddr held 0x10, imemREN=1 throughout, no push; on ihit, entry {0x10,data} appears next cycle.
- Backpressure/full: instr_ready=0, ihit=1 → exactly 4 pushes (PCs 0..C), imemREN=0, state FULL. One pop → imemREN=1 at PC=0x10 next cycle.
- Redirect: 3 entries queued, redirect=1, redirect_pc=0x103, ihit=1 same cycle → hit discarded; next cycle instr_valid=0, imemaddr=0x100.
- Halt: halt pulse at PC=0x20 → imemREN=0 indefinitely, FIFO drains, PC stays 0x20; redirect to 0x40 → fetching resumes at 0x40.
- Async reset mid-miss: nRST low between edges → outputs immediately reset, imemaddr=RESET_PC, instr_valid=0.
